// File: rtl/boc_search_pkg.sv
// Package for the BOC acquisition search sequencer.
// Holds the sequencer state encoding, the default port widths and the
// number of cycles the code generator is held in reset while a bin loads.
package boc_search_pkg;

    localparam int DEF_ACC_WIDTH    = 32;
    localparam int DEF_ENERGY_WIDTH = 24;
    localparam int DEF_BIN_WIDTH    = 8;
    localparam int DEF_DWELL_WIDTH  = 6;

    // Generator reset hold per bin; covers the generator ROM latency.
    localparam int LOAD_HOLD = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_WAIT_E,
        ST_EVAL,
        ST_STEP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/boc_bin_stepper.sv
// One search axis: a bin index counter plus its accumulated value.
//   clear       : idx <= 0, val <= init
//   step        : idx <= idx+1, val <= val+inc (mod 2^VAL_WIDTH);
//                 when already on the last bin it wraps to idx 0 / val init
//   count       : number of bins on this axis (0 is treated as 1)
//   idx, val    : current bin index and accumulated value
//   last        : current bin is the last one on this axis (wrap flag)
module boc_bin_stepper #(
    parameter int IDX_WIDTH = 8,
    parameter int VAL_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 step,
    input  logic [VAL_WIDTH-1:0] init,
    input  logic [VAL_WIDTH-1:0] inc,
    input  logic [IDX_WIDTH-1:0] count,
    output logic [IDX_WIDTH-1:0] idx,
    output logic [VAL_WIDTH-1:0] val,
    output logic                 last
);

    logic [IDX_WIDTH-1:0] top_idx;

    assign top_idx = (count == '0) ? '0 : count - IDX_WIDTH'(1);
    assign last    = (idx == top_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= '0;
            val <= '0;
        end else if (clear || (step && last)) begin
            idx <= '0;
            val <= init;
        end else if (step) begin
            idx <= idx + IDX_WIDTH'(1);
            val <= val + inc;
        end
    end

endmodule

// File: rtl/boc_search_ctrl.sv
// Acquisition search sequencer for one BOC correlator channel.
// Walks a code-phase (inner) x Doppler (outer) grid; per bin it holds the
// code generator in reset while the new phase/FCW load, dwells for a number
// of code periods, collects the correlator energy and tracks the maximum.
//
// Optional feature macro: SEARCH_THRESH_EN -- when defined, a bin energy
// >= rx_thresh is recorded as best and ends the search immediately.
//
// Ports:
//   rx_clk, rx_rst_n      clock, synchronous active-low reset
//   rx_start, rx_abort    start pulse (IDLE only), abort (any state -> IDLE)
//   rx_fcw_base/step      Doppler bin 0 FCW and per-bin increment
//   rx_dopp_bins          Doppler bin count (0 -> 1)
//   rx_phs_step/bins      code-phase increment and bin count (0 -> 1)
//   rx_dwell              code periods per bin (0 -> 1)
//   rx_thresh             early-stop threshold (SEARCH_THRESH_EN only)
//   rx_prn_eop            end-of-period pulse from the code generator
//   rx_corr_valid/energy  correlator energy result
//   tx_gen_rst            code generator reset (high in IDLE and LOAD)
//   tx_corr_paral_en      init-phase load enable (high while busy)
//   tx_prn_fcw, tx_init_phs  current bin FCW and initial phase
//   tx_busy, tx_done      search active, one-cycle completion pulse
//   tx_best_*             indices and energy of the strongest bin
module boc_search_ctrl
    import boc_search_pkg::*;
#(
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int ENERGY_WIDTH = DEF_ENERGY_WIDTH,
    parameter int BIN_WIDTH    = DEF_BIN_WIDTH,
    parameter int DWELL_WIDTH  = DEF_DWELL_WIDTH
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst_n,
    input  logic                    rx_start,
    input  logic                    rx_abort,
    input  logic [ACC_WIDTH-1:0]    rx_fcw_base,
    input  logic [ACC_WIDTH-1:0]    rx_fcw_step,
    input  logic [BIN_WIDTH-1:0]    rx_dopp_bins,
    input  logic [ACC_WIDTH-1:0]    rx_phs_step,
    input  logic [BIN_WIDTH-1:0]    rx_phs_bins,
    input  logic [DWELL_WIDTH-1:0]  rx_dwell,
    input  logic [ENERGY_WIDTH-1:0] rx_thresh,
    input  logic                    rx_prn_eop,
    input  logic                    rx_corr_valid,
    input  logic [ENERGY_WIDTH-1:0] rx_corr_energy,
    output logic                    tx_gen_rst,
    output logic                    tx_corr_paral_en,
    output logic [ACC_WIDTH-1:0]    tx_prn_fcw,
    output logic [ACC_WIDTH-1:0]    tx_init_phs,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic [BIN_WIDTH-1:0]    tx_best_phs_idx,
    output logic [BIN_WIDTH-1:0]    tx_best_dopp_idx,
    output logic [ENERGY_WIDTH-1:0] tx_best_energy
);

    state_t state, state_next;

    logic [1:0]              load_cnt;
    logic [DWELL_WIDTH-1:0]  eop_cnt;
    logic [DWELL_WIDTH-1:0]  dwell_last;
    logic [ENERGY_WIDTH-1:0] energy_q;
    logic [BIN_WIDTH-1:0]    phs_idx, dopp_idx;
    logic                    phs_last, dopp_last, grid_last;
    logic                    idle, phs_step_en, dopp_step_en;
    logic                    gen_rst, busy, done;
    logic                    best_clr, capture, best_upd, step_en;
    logic [ACC_WIDTH-1:0]    zero_phs;

    assign dwell_last = (rx_dwell == '0) ? '0 : rx_dwell - DWELL_WIDTH'(1);
    assign grid_last  = phs_last && dopp_last;
    assign idle       = (state == ST_IDLE);
    assign zero_phs   = '0;

    // Phase is the inner loop; the final STEP leaves both axes untouched.
    assign phs_step_en  = step_en && !grid_last;
    assign dopp_step_en = step_en && phs_last && !dopp_last;

`ifdef SEARCH_THRESH_EN
    logic thresh_hit;
    assign thresh_hit = (energy_q >= rx_thresh);
`else
    logic thresh_unused;
    assign thresh_unused = ^rx_thresh;
`endif

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        gen_rst    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        best_clr   = 1'b0;
        capture    = 1'b0;
        best_upd   = 1'b0;
        step_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                gen_rst = 1'b1;
                busy    = 1'b0;
                if (rx_start) begin
                    best_clr   = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                gen_rst = 1'b1;
                if (load_cnt == 2'(LOAD_HOLD - 1)) state_next = ST_DWELL;
            end
            ST_DWELL: begin
                if (rx_prn_eop && (eop_cnt == dwell_last)) state_next = ST_WAIT_E;
            end
            ST_WAIT_E: begin
                if (rx_corr_valid) begin
                    capture    = 1'b1;
                    state_next = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_next = ST_STEP;
                if (energy_q > tx_best_energy) best_upd = 1'b1;
`ifdef SEARCH_THRESH_EN
                if (thresh_hit) begin
                    best_upd   = 1'b1;
                    state_next = ST_DONE;
                end
`endif
            end
            ST_STEP: begin
                step_en    = 1'b1;
                state_next = grid_last ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort wins over every transition and suppresses all side effects.
        if (rx_abort) begin
            state_next = ST_IDLE;
            best_clr   = 1'b0;
            capture    = 1'b0;
            best_upd   = 1'b0;
            step_en    = 1'b0;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            load_cnt         <= '0;
            eop_cnt          <= '0;
            energy_q         <= '0;
            tx_best_energy   <= '0;
            tx_best_phs_idx  <= '0;
            tx_best_dopp_idx <= '0;
        end else begin
            load_cnt <= (state == ST_LOAD) ? load_cnt + 2'd1 : 2'd0;
            if (state != ST_DWELL)  eop_cnt <= '0;
            else if (rx_prn_eop)    eop_cnt <= eop_cnt + DWELL_WIDTH'(1);
            if (capture) energy_q <= rx_corr_energy;
            if (best_clr) begin
                tx_best_energy   <= '0;
                tx_best_phs_idx  <= '0;
                tx_best_dopp_idx <= '0;
            end else if (best_upd) begin
                tx_best_energy   <= energy_q;
                tx_best_phs_idx  <= phs_idx;
                tx_best_dopp_idx <= dopp_idx;
            end
        end
    end

    boc_bin_stepper #(.IDX_WIDTH(BIN_WIDTH), .VAL_WIDTH(ACC_WIDTH)) u_phs (
        .clk   (rx_clk),
        .rst_n (rx_rst_n),
        .clear (idle),
        .step  (phs_step_en),
        .init  (zero_phs),
        .inc   (rx_phs_step),
        .count (rx_phs_bins),
        .idx   (phs_idx),
        .val   (tx_init_phs),
        .last  (phs_last)
    );

    boc_bin_stepper #(.IDX_WIDTH(BIN_WIDTH), .VAL_WIDTH(ACC_WIDTH)) u_dopp (
        .clk   (rx_clk),
        .rst_n (rx_rst_n),
        .clear (idle),
        .step  (dopp_step_en),
        .init  (rx_fcw_base),
        .inc   (rx_fcw_step),
        .count (rx_dopp_bins),
        .idx   (dopp_idx),
        .val   (tx_prn_fcw),
        .last  (dopp_last)
    );

    assign tx_gen_rst       = gen_rst;
    assign tx_busy          = busy;
    assign tx_corr_paral_en = busy;
    assign tx_done          = done;

endmodule

// File: tb/tb_boc_search_ctrl.sv
// Self-checking bench for boc_search_ctrl: fixed search vectors, a few
// hand-written corner sequences and randomized grids, all checked against
// a grid-walk model of the search (bin order, per-bin phase/FCW, strict max).
module tb_boc_search_ctrl;

`ifdef SEARCH_THRESH_EN
    localparam bit THR_EN = 1'b1;
`else
    localparam bit THR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic        eop = 1'b0, cvalid = 1'b0;
    logic [31:0] fcw_base = '0, fcw_step = '0, phs_step = '0;
    logic [7:0]  dopp_bins = '0, phs_bins = '0;
    logic [5:0]  dwell = '0;
    logic [23:0] thresh = '1, energy = '0;
    logic        gen_rst, paral_en, busy, done;
    logic [31:0] prn_fcw, init_phs;
    logic [7:0]  best_p, best_d;
    logic [23:0] best_e;

    int checks = 0, failures = 0, done_cnt = 0;
    logic [23:0] en [64];

    typedef struct {
        int          pb, db, dw;
        logic [31:0] base, fs, ps;
        logic [23:0] e [4];
        int          exp_p, exp_d;
        logic [23:0] exp_e;
    } vec_t;
    vec_t vec [6];

    boc_search_ctrl dut (
        .rx_clk(clk), .rx_rst_n(rst_n), .rx_start(start), .rx_abort(abort),
        .rx_fcw_base(fcw_base), .rx_fcw_step(fcw_step), .rx_dopp_bins(dopp_bins),
        .rx_phs_step(phs_step), .rx_phs_bins(phs_bins), .rx_dwell(dwell),
        .rx_thresh(thresh), .rx_prn_eop(eop), .rx_corr_valid(cvalid),
        .rx_corr_energy(energy), .tx_gen_rst(gen_rst), .tx_corr_paral_en(paral_en),
        .tx_prn_fcw(prn_fcw), .tx_init_phs(init_phs), .tx_busy(busy), .tx_done(done),
        .tx_best_phs_idx(best_p), .tx_best_dopp_idx(best_d), .tx_best_energy(best_e)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered on the first visible LOAD cycle; the generator must be held for two.
    task automatic load_phase(output bit ok);
        chk("load1_gen_rst", gen_rst, 1);
        chk("load1_busy", busy, 1);
        tick;
        chk("load2_gen_rst", gen_rst, 1);
        tick;
        chk("dwell_gen_rst", gen_rst, 0);
        ok = (gen_rst === 1'b0);
    endtask

    // Full dwell, optionally with stray correlator pulses (must be ignored),
    // then deliver the bin energy in WAIT_E.
    task automatic dwell_energy(input int w, input logic [23:0] e, input bit noise);
        for (int k = 0; k < w; k++) begin
            if (noise) begin
                cvalid = 1'b1; energy = '1;
                tick;
                cvalid = 1'b0; energy = '0;
                chk("dwell_hold_gen_rst", gen_rst, 0);
            end
            eop = 1'b1;
            tick;
            eop = 1'b0;
        end
        if (noise) begin
            eop = 1'b1;
            tick;
            eop = 1'b0;
        end
        tick;
        cvalid = 1'b1; energy = e;
        tick;
        cvalid = 1'b0; energy = '0;
    endtask

    task automatic run_search(input int pb, input int db, input int dw,
                              input logic [31:0] base, input logic [31:0] fs,
                              input logic [31:0] ps, input logic [23:0] thr,
                              input bit noise, input int abort_at,
                              output int mp, output int md, output logic [23:0] me);
        int P, D, W, n, d0;
        bit ok, stop, finished, early, sdone, sload, exp_done;
        logic [31:0] pexp, fexp;
        P = (pb == 0) ? 1 : pb;
        D = (db == 0) ? 1 : db;
        W = (dw == 0) ? 1 : dw;
        phs_bins = 8'(pb); dopp_bins = 8'(db); dwell = 6'(dw);
        fcw_base = base; fcw_step = fs; phs_step = ps; thresh = thr;
        mp = 0; md = 0; me = '0;
        stop = 0; finished = 0;
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int d = 0; d < D && !stop; d++) begin
            for (int p = 0; p < P && !stop; p++) begin
                n = d * P + p;
                load_phase(ok);
                if (!ok) begin
                    abort = 1'b1; tick; abort = 1'b0;
                    stop = 1;
                end else begin
                    pexp = ps * 32'(p);
                    fexp = base + fs * 32'(d);
                    chk("bin_init_phs", init_phs, pexp);
                    chk("bin_prn_fcw", prn_fcw, fexp);
                    if (n == abort_at) begin
                        eop = 1'b1; tick; eop = 1'b0;
                        abort = 1'b1; tick; abort = 1'b0;
                        chk("abort_gen_rst", gen_rst, 1);
                        chk("abort_busy", busy, 0);
                        chk("abort_done", done, 0);
                        tick; tick;
                        chk("abort_no_done_pulse", done_cnt - d0, 0);
                        chk("abort_best_e", best_e, me);
                        chk("abort_best_p", best_p, mp);
                        chk("abort_best_d", best_d, md);
                        stop = 1;
                    end else begin
                        early = 0;
                        if (THR_EN && en[n] >= thr) begin
                            mp = p; md = d; me = en[n]; early = 1;
                        end else if (en[n] > me) begin
                            mp = p; md = d; me = en[n];
                        end
                        dwell_energy(W, en[n], noise);
                        tick;
                        chk("bin_best_e", best_e, me);
                        chk("bin_best_p", best_p, mp);
                        chk("bin_best_d", best_d, md);
                        sdone = 0; sload = 0;
                        for (int w = 0; w < 6 && !sdone && !sload; w++) begin
                            if (done === 1'b1)         sdone = 1;
                            else if (gen_rst === 1'b1) sload = 1;
                            else                       tick;
                        end
                        exp_done = early || (d == D - 1 && p == P - 1);
                        chk("bin_end_done", sdone, exp_done);
                        chk("bin_end_reload", sload, !exp_done);
                        if (sdone !== exp_done || (!sdone && !sload)) begin
                            abort = 1'b1; tick; abort = 1'b0;
                            stop = 1;
                        end else if (exp_done) begin
                            stop = 1; finished = 1;
                        end
                    end
                end
            end
        end
        if (finished) begin
            tick;
            chk("done_one_cycle", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_gen_rst", gen_rst, 1);
            chk("idle_paral_en", paral_en, 0);
            tick;
            chk("idle_fcw_base", prn_fcw, base);
            chk("idle_init_phs", init_phs, 0);
            chk("done_pulses", done_cnt - d0, 1);
            chk("final_best_e", best_e, me);
            chk("final_best_p", best_p, mp);
            chk("final_best_d", best_d, md);
        end
        tick;
    endtask

    initial begin
        int mp, md;
        logic [23:0] me;
        bit ok;

        vec[0] = '{2, 2, 1, 32'h1000, 32'h10, 32'h100, '{24'd5, 24'd9, 24'd3, 24'd9}, 1, 0, 24'd9};
        vec[1] = '{1, 2, 2, 32'h8, 32'hFFFF_FFF0, 32'h40, '{24'd7, 24'd8, 24'd0, 24'd0}, 0, 1, 24'd8};
        vec[2] = '{0, 0, 0, 32'hABC, 32'h5, 32'h7, '{24'd4, 24'd0, 24'd0, 24'd0}, 0, 0, 24'd4};
        vec[3] = '{2, 1, 1, 32'h0, 32'h1, 32'h1, '{24'd0, 24'd0, 24'd0, 24'd0}, 0, 0, 24'd0};
        vec[4] = '{4, 1, 2, 32'h20, 32'h3, 32'hFFFF_FF00, '{24'd9, 24'd8, 24'd7, 24'd6}, 0, 0, 24'd9};
        vec[5] = '{1, 3, 1, 32'hFFFF_FFFF, 32'h2, 32'h0, '{24'd3, 24'd6, 24'd6, 24'd0}, 0, 1, 24'd6};

        // Reset values: FCW stays 0 under reset even though IDLE would load the base.
        fcw_base = 32'h1234;
        tick; tick;
        chk("rst_gen_rst", gen_rst, 1);
        chk("rst_paral_en", paral_en, 0);
        chk("rst_prn_fcw", prn_fcw, 0);
        chk("rst_init_phs", init_phs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_best_e", best_e, 0);
        chk("rst_best_idx", {best_p, best_d}, 0);
        rst_n = 1'b1;
        tick;
        chk("idle_tracks_fcw_base", prn_fcw, 32'h1234);

        // Abort outranks start in IDLE.
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("abort_vs_start_busy", busy, 0);
        chk("abort_vs_start_gen_rst", gen_rst, 1);
        tick;

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) en[k] = vec[i].e[k];
            run_search(vec[i].pb, vec[i].db, vec[i].dw, vec[i].base, vec[i].fs, vec[i].ps,
                       '1, 1'b0, -1, mp, md, me);
            chk($sformatf("vec%0d_best_e", i), best_e, vec[i].exp_e);
            chk($sformatf("vec%0d_best_p", i), best_p, vec[i].exp_p);
            chk($sformatf("vec%0d_best_d", i), best_d, vec[i].exp_d);
        end

        // Three-period dwell with stray correlator pulses during DWELL.
        en[0] = 24'd4; en[1] = 24'd7;
        run_search(2, 1, 3, 32'h100, 32'h1, 32'h33, '1, 1'b1, -1, mp, md, me);
        chk("dwell3_best_e", best_e, 24'd7);
        chk("dwell3_best_p", best_p, 1);

        // Abort in DWELL of the second bin keeps the partial best.
        en[0] = 24'd6; en[1] = 24'd2; en[2] = 24'd1; en[3] = 24'd1;
        run_search(2, 2, 2, 32'h0, 32'h1, 32'h1, '1, 1'b0, 1, mp, md, me);
        chk("abort_partial_best", best_e, 24'd6);

        // Reset mid-search returns everything to reset values.
        phs_bins = 8'd2; dopp_bins = 8'd1; dwell = 6'd1;
        fcw_base = 32'h55; phs_step = 32'h10;
        start = 1'b1; tick; start = 1'b0;
        load_phase(ok);
        dwell_energy(1, 24'd5, 1'b0);
        tick;
        chk("pre_reset_best_e", best_e, 24'd5);
        rst_n = 1'b0;
        tick;
        chk("midrst_gen_rst", gen_rst, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_prn_fcw", prn_fcw, 0);
        chk("midrst_init_phs", init_phs, 0);
        chk("midrst_best_e", best_e, 0);
        rst_n = 1'b1;
        tick;
        chk("post_rst_fcw_base", prn_fcw, 32'h55);
        tick;

`ifdef SEARCH_THRESH_EN
        en[0] = 24'd5; en[1] = 24'd9; en[2] = 24'd3; en[3] = 24'd9;
        run_search(2, 2, 1, 32'h1000, 32'h10, 32'h100, 24'd8, 1'b0, -1, mp, md, me);
        chk("thresh_best_e", best_e, 24'd9);
        chk("thresh_best_p", best_p, 1);
        chk("thresh_best_d", best_d, 0);
`endif

        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 64; k++)
                en[k] = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 15))
                                                    : 24'($urandom) & 24'hFF_FFFE;
            run_search($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom, $urandom, $urandom, '1, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0) ? 1 : -1, mp, md, me);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
